multi_channel_fade_pwm: RTL and testbench
=========================================

// Module: multi_channel_fade_pwm
// PURPOSE
//  Parametrised N-channel fade engine with an integrated PWM output stage, driving an RGB/LED bank directly.
//  Each channel runs a triangle or sawtooth duty ramp with a fixed per-channel phase offset, which produces
//  a rainbow hue rotation when NUM_CH=3. Everything runs in the single clk domain, with no derived clocks.
//  Sits between the top level and the LED pins; the pin-level polarity inverter lives in the top level.
// PARAMETERS
//  NUM_CH          3      number of independent fade/PWM channels (>=1)
//  PWM_INTERVAL    1200   clk cycles per PWM period
//  STEP_INTERVAL   12000  clk cycles per fade step (1 ms at 12 MHz)
//  STEPS_PER_RAMP  166    steps in one rising (or falling) ramp
//  STEP_VAL        PWM_INTERVAL/STEPS_PER_RAMP; duty increment per step (7 by default)
//  DUTY_W          $clog2(PWM_INTERVAL+1); duty/PWM counter width
// PORTS
//  clk         in   1                 system clock, 12 MHz
//  rst_n       in   1                 asynchronous active-low reset
//  enable      in   1                 1 = fade steps advance; 0 = phases frozen, PWM keeps running
//  mode        in   2                 fade_mode_e: TRIANGLE=0, SAWTOOTH=1, HOLD=2, OFF=3
//  restart     in   1                 1-cycle pulse; reload all phases to their offsets, clear step prescaler
//  pwm_out     out  NUM_CH            per-channel PWM, active high
//  duty        out  NUM_CH x DUTY_W   active duty value per channel (the one being applied)
//  step_tick   out  1                 1-cycle pulse on each fade step
//  cycle_done  out  1                 1-cycle pulse when channel 0 phase wraps to 0
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - pwm_out=0, duty=0, step_tick=0, cycle_done=0.
//    - PWM counter=0, prescaler=0.
//    - phase[i] = OFFSET(i) = (i*2*STEPS_PER_RAMP)/NUM_CH.
//  - Prescaler:
//    - counts 0..STEP_INTERVAL-1 while enable=1.
//    - on reaching STEP_INTERVAL-1 it wraps and asserts step_tick for 1 cycle.
//    - holds its value while enable=0.
//  - Phase per channel:
//    - range 0..2*STEPS_PER_RAMP-1.
//    - on step_tick, increments with wrap unless mode is HOLD or OFF.
//  - Target duty:
//    - TRIANGLE: p<S ? p*STEP_VAL : (2S-p)*STEP_VAL, with S=STEPS_PER_RAMP.
//    - SAWTOOTH: (p mod S)*STEP_VAL.
//    - HOLD: current target retained.
//    - OFF: 0.
//    - Peak value is S*STEP_VAL (1162) and must not exceed PWM_INTERVAL; enforced by an elaboration check.
//  - Duty shadowing:
//    - target is copied to duty[i] only on the PWM period boundary (pwm_cnt==PWM_INTERVAL-1), so there are no mid-period glitches.
//    - exception: OFF zeroes duty and pwm_out on the next clk, without waiting for the boundary.
//  - PWM:
//    - shared counter 0..PWM_INTERVAL-1, free-running from reset regardless of enable.
//    - pwm_out[i] is registered: pwm_out[i] <= (pwm_cnt < duty[i]).
//    - duty=0 gives constant low; duty=PWM_INTERVAL gives constant high.
//  - cycle_done: pulses on the same cycle that phase[0] is written 2S-1 -> 0 (registered alongside the phase).
//  - Simultaneous events:
//    - restart in the same cycle as step_tick: restart wins, phases load their offsets, no increment.
//    - restart resets the prescaler to 0 but never the PWM counter.
//  - Mode change is sampled every cycle and takes effect at the next step_tick (phase) or PWM boundary (duty).
//  - Reset mid-operation: all state returns to reset values immediately; there is no partial-period output.
// STRUCTURE
//  - fade_pkg: fade_mode_e enum; function tri_duty(p), function saw_duty(p).
//  - Sub-module fade_channel: one phase counter plus target/shadow duty, instantiated NUM_CH times in a generate loop.
//  - Top level owns the prescaler, PWM counter, cycle_done and the elaboration check.
// TESTING
//  1. Reset with NUM_CH=3 -> phases 0/110/221; all outputs 0; first step_tick at clk cycle 12000 after rst_n rises.
//  2. TRIANGLE, ch0 -> duty steps 0,7,14,... peaks 1162 at step 166, returns to 0 at step 332; cycle_done pulses once.
//  3. Duty=7 -> pwm_out high exactly 7 of every 1200 cycles; duty value changes only at the pwm_cnt==1199 boundary.
//  4. HOLD for 5 step_ticks, then TRIANGLE -> phases unchanged during HOLD, then resume from the held value.
//  5. OFF mid-period with duty=600 -> pwm_out=0 by the next clk; duty=0; phases retained; TRIANGLE restores output.
//  6. restart coincident with step_tick, and rst_n pulsed low mid-ramp -> offsets reloaded, no increment; full reset state.

Source files
------------

// File: rtl/multi_channel_fade_pwm_pkg.sv
// Shared types and duty-curve helpers for the multi-channel fade/PWM engine.
package multi_channel_fade_pwm_pkg;

  typedef enum logic [1:0] {
    TRIANGLE = 2'd0,
    SAWTOOTH = 2'd1,
    HOLD     = 2'd2,
    OFF      = 2'd3
  } fade_mode_e;

  // Rises for the first s phases, then mirrors back down to zero.
  function automatic int unsigned tri_duty(input int unsigned p, input int unsigned s,
                                           input int unsigned step_val);
    return (p < s) ? p * step_val : (2 * s - p) * step_val;
  endfunction

  function automatic int unsigned saw_duty(input int unsigned p, input int unsigned s,
                                           input int unsigned step_val);
    return (p % s) * step_val;
  endfunction

  function automatic int unsigned phase_offset(input int unsigned idx, input int unsigned num_ch,
                                               input int unsigned s);
    return (idx * 2 * s) / num_ch;
  endfunction

endpackage

// File: rtl/multi_channel_fade_pwm_channel.sv
// One fade channel: phase counter, target duty, period-aligned shadow duty and PWM flop.
module multi_channel_fade_pwm_channel
  import multi_channel_fade_pwm_pkg::*;
#(
  parameter int unsigned     STEPS_PER_RAMP = 166,
  parameter int unsigned     STEP_VAL       = 7,
  parameter int unsigned     DUTY_W         = 11,
  parameter int unsigned     PH_W           = 9,
  parameter logic [PH_W-1:0] OFFSET         = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  fade_mode_e        mode,
  input  logic              step_tick,
  input  logic              restart,
  input  logic              pwm_boundary,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm_out,
  output logic              wrap
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * STEPS_PER_RAMP - 1);

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic              advance;

  always_comb begin
    advance = step_tick && (mode == TRIANGLE || mode == SAWTOOTH);
    phase_d = phase_q;
    wrap    = 1'b0;
    // restart has priority over a coincident step so the offsets load cleanly
    if (restart) begin
      phase_d = OFFSET;
    end else if (advance) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        wrap    = 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    case (mode)
      TRIANGLE: target_d = DUTY_W'(tri_duty(32'(phase_q), STEPS_PER_RAMP, STEP_VAL));
      SAWTOOTH: target_d = DUTY_W'(saw_duty(32'(phase_q), STEPS_PER_RAMP, STEP_VAL));
      HOLD:     target_d = target_q;
      default:  target_d = '0;
    endcase

    // OFF bypasses the period boundary so the LED goes dark on the next clock
    if (mode == OFF)       duty_d = '0;
    else if (pwm_boundary) duty_d = target_q;
    else                   duty_d = duty_q;

    pwm_d = (mode != OFF) && (pwm_cnt < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= OFFSET;
      target_q <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
    end
  end

  assign duty    = duty_q;
  assign pwm_out = pwm_q;

endmodule

// File: rtl/multi_channel_fade_pwm.sv
// N-channel fade engine: shared step prescaler and PWM counter feeding per-channel fade/PWM slices.
module multi_channel_fade_pwm
  import multi_channel_fade_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned PWM_INTERVAL   = 1200,
  parameter int unsigned STEP_INTERVAL  = 12000,
  parameter int unsigned STEPS_PER_RAMP = 166,
  parameter int unsigned STEP_VAL       = PWM_INTERVAL / STEPS_PER_RAMP,
  parameter int unsigned DUTY_W         = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  fade_mode_e                    mode,
  input  logic                          restart,
  output logic [NUM_CH-1:0]             pwm_out,
  output logic [NUM_CH-1:0][DUTY_W-1:0] duty,
  output logic                          step_tick,
  output logic                          cycle_done
);

  localparam int unsigned       PH_W     = $clog2(2 * STEPS_PER_RAMP);
  localparam int unsigned       PRE_W    = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_INTERVAL - 1);
  localparam logic [DUTY_W-1:0] PWM_LAST = DUTY_W'(PWM_INTERVAL - 1);
  localparam logic [NUM_CH-1:0] CH0_MASK = NUM_CH'(1);

  if (STEPS_PER_RAMP * STEP_VAL > PWM_INTERVAL) begin : g_bad_peak
    $error("fade peak STEPS_PER_RAMP*STEP_VAL exceeds PWM_INTERVAL");
  end
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1");
  end

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              step_tick_q, step_tick_d;
  logic              cycle_done_q, cycle_done_d;
  logic              pwm_boundary;
  logic [NUM_CH-1:0] wrap;

  always_comb begin
    pwm_boundary = (pwm_cnt_q == PWM_LAST);
    pwm_cnt_d    = pwm_boundary ? '0 : pwm_cnt_q + 1'b1;

    pre_d       = pre_q;
    step_tick_d = 1'b0;
    if (restart) begin
      pre_d = '0;
    end else if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d       = '0;
        step_tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    // only channel 0's phase wrap marks a full colour cycle
    cycle_done_d = |(wrap & CH0_MASK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      pwm_cnt_q    <= '0;
      step_tick_q  <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      pwm_cnt_q    <= pwm_cnt_d;
      step_tick_q  <= step_tick_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_channel_fade_pwm_channel #(
      .STEPS_PER_RAMP(STEPS_PER_RAMP),
      .STEP_VAL      (STEP_VAL),
      .DUTY_W        (DUTY_W),
      .PH_W          (PH_W),
      .OFFSET        (PH_W'(phase_offset(i, NUM_CH, STEPS_PER_RAMP)))
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .step_tick   (step_tick_q),
      .restart     (restart),
      .pwm_boundary(pwm_boundary),
      .pwm_cnt     (pwm_cnt_q),
      .duty        (duty[i]),
      .pwm_out     (pwm_out[i]),
      .wrap        (wrap[i])
    );
  end

  assign step_tick  = step_tick_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_multi_channel_fade_pwm.sv
// Directed bench for multi_channel_fade_pwm with shrunken timing: PWM 20, step 40, ramp 4 steps of 5.
module tb_multi_channel_fade_pwm;
  import multi_channel_fade_pwm_pkg::*;

  localparam int NUM_CH = 3;
  localparam int DW     = 5;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      enable = 1'b0;
  logic                      restart = 1'b0;
  fade_mode_e                mode = TRIANGLE;
  logic [NUM_CH-1:0]         pwm_out;
  logic [NUM_CH-1:0][DW-1:0] duty;
  logic                      step_tick;
  logic                      cycle_done;

  int n_vec  = 0;
  int n_err  = 0;
  int cd_cnt = 0;

  typedef struct {
    fade_mode_e mode;
    int         d0;
    int         d1;
    int         d2;
    int         cd;
  } vec_t;

  vec_t vecs[12];

  multi_channel_fade_pwm #(
    .NUM_CH        (NUM_CH),
    .PWM_INTERVAL  (20),
    .STEP_INTERVAL (40),
    .STEPS_PER_RAMP(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .restart   (restart),
    .pwm_out   (pwm_out),
    .duty      (duty),
    .step_tick (step_tick),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cycle_done) cd_cnt++;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_duty(input string name, input int e0, input int e1, input int e2);
    check($sformatf("%s_duty0", name), int'(duty[0]), e0);
    check($sformatf("%s_duty1", name), int'(duty[1]), e1);
    check($sformatf("%s_duty2", name), int'(duty[2]), e2);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_tick && n < 200);
    if (!step_tick) begin
      n_vec++;
      n_err++;
      $display("FAIL step_tick_timeout: got no pulse, expected one within 200 cycles");
    end
  endtask

  // one fade step, then settle past the next PWM boundary so duty reflects the new phase
  task automatic do_step();
    int n;
    wait_tick(n);
    repeat (22) @(negedge clk);
  endtask

  initial begin
    int n, cd0, hi0, hi1, hi2;

    // phases after the step that precedes the table: 1/3/6
    vecs[0]  = '{TRIANGLE, 10, 20,  5, 0};
    vecs[1]  = '{TRIANGLE, 15, 15,  0, 0};
    vecs[2]  = '{TRIANGLE, 20, 10,  5, 0};
    vecs[3]  = '{HOLD,     20, 10,  5, 0};
    vecs[4]  = '{HOLD,     20, 10,  5, 0};
    vecs[5]  = '{TRIANGLE, 15,  5, 10, 0};
    vecs[6]  = '{SAWTOOTH, 10,  0, 15, 0};
    vecs[7]  = '{SAWTOOTH, 15,  5,  0, 0};
    vecs[8]  = '{SAWTOOTH,  0, 10,  5, 1};
    vecs[9]  = '{TRIANGLE,  5, 15, 10, 0};
    vecs[10] = '{OFF,       0,  0,  0, 0};
    vecs[11] = '{TRIANGLE, 10, 20,  5, 0};

    mode   = TRIANGLE;
    enable = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check_duty("reset", 0, 0, 0);
    check("reset_step_tick", int'(step_tick), 0);
    check("reset_cycle_done", int'(cycle_done), 0);

    rst_n = 1'b1;
    wait_tick(n);
    check("first_tick_latency", n, 40);
    check_duty("first_tick", 0, 10, 15);
    repeat (22) @(negedge clk);
    check_duty("after_step1", 5, 15, 10);

    for (int i = 0; i < 12; i++) begin
      mode = vecs[i].mode;
      cd0  = cd_cnt;
      do_step();
      check_duty($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].d2);
      check($sformatf("vec%0d_cycle_done", i), cd_cnt - cd0, vecs[i].cd);
    end

    // high-time over one full PWM period with duties 10/20/5
    hi0 = 0; hi1 = 0; hi2 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      hi2 += int'(pwm_out[2]);
    end
    check("pwm_high_ch0", hi0, 10);
    check("pwm_high_ch1", hi1, 20);
    check("pwm_high_ch2", hi2, 5);

    // phases now 3/5/0 (duty0 15); next step moves ch0 to 20 at the following boundary
    wait_tick(n);
    n = 0;
    while (int'(duty[0]) == 15 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("duty_update_delay", n, 20);
    check("duty_update_value", int'(duty[0]), 20);

    // OFF mid-period: output and duty clear on the next clock
    repeat (7) @(negedge clk);
    mode = OFF;
    @(negedge clk);
    check("off_pwm_out", int'(pwm_out), 0);
    check_duty("off_next_clk", 0, 0, 0);
    do_step();
    check("off_step_pwm_out", int'(pwm_out), 0);
    check_duty("off_step", 0, 0, 0);
    mode = TRIANGLE;
    do_step();
    check_duty("off_resume", 15, 5, 10);

    // restart coincident with step_tick
    wait_tick(n);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_tick(n);
    check("restart_tick_latency", n, 40);
    check_duty("restart_offsets", 0, 10, 15);

    // asynchronous reset mid-ramp
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_pwm_out", int'(pwm_out), 0);
    check_duty("midreset", 0, 0, 0);
    check("midreset_step_tick", int'(step_tick), 0);
    check("midreset_cycle_done", int'(cycle_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n);
    check("midreset_tick_latency", n, 40);
    check_duty("midreset_restart", 0, 10, 15);

    // enable low freezes the prescaler
    enable = 1'b0;
    repeat (30) @(negedge clk);
    enable = 1'b1;
    wait_tick(n);
    check("enable_freeze_latency", n, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
